alu_ctrl_ex_stage: RTL



---
 rtl/alu_ctrl_ex_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_ex_stage.sv
// ALU-control decode stage at the ID/EX boundary.
// Registers the RV32I/M ALU opcode and runs a busy FSM for mul/div latency.
module alu_ctrl_ex_stage #(
   parameter int CTRL_W  = 4,
   parameter int EN_M    = 1,
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [1:0]        aluop,
   input  logic [2:0]        funct3,
   input  logic              funct7_5,
   input  logic              funct7_0,
   input  logic              stall_in,
   input  logic              flush,
   output logic [CTRL_W-1:0] alu_control,
   output logic              is_md,
   output logic [2:0]        md_op,
   output logic              illegal,
   output logic              out_valid,
   output logic              stall_req
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;

   typedef enum logic {IDLE, MD_BUSY} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [CTRL_W-1:0] ctrl_n;
   logic              md_n, ill_n, vld_n;
   logic [2:0]        mdop_n;

   logic [3:0] dec_op;
   logic       dec_md, dec_ill;

   always_comb begin
      dec_op  = OP_ADD;
      dec_md  = 1'b0;
      dec_ill = 1'b0;
      unique case (aluop)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = OP_SUB;
         default: begin
            unique case (funct3)
               3'b000: dec_op = (aluop == 2'b10 && funct7_5) ? OP_SUB : OP_ADD;
               3'b001: dec_op = OP_SLL;
               3'b010: dec_op = OP_SLT;
               3'b011: dec_op = OP_SLTU;
               3'b100: dec_op = OP_XOR;
               3'b101: dec_op = funct7_5 ? OP_SRA : OP_SRL;
               3'b110: dec_op = OP_OR;
               3'b111: dec_op = OP_AND;
            endcase
            // Only R-type carries funct7 meaning beyond the shift selector
            if (aluop == 2'b10) begin
               if (funct7_0) begin
                  if (EN_M == 0 || funct7_5) dec_ill = 1'b1;
                  else                       dec_md  = 1'b1;
               end else if (funct7_5 && funct3 != 3'b000 && funct3 != 3'b101) begin
                  dec_ill = 1'b1;
               end
               if (dec_ill || dec_md) dec_op = OP_ADD;
            end
         end
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ctrl_n  = alu_control;
      md_n    = is_md;
      mdop_n  = md_op;
      ill_n   = illegal;
      vld_n   = out_valid;
      if (flush) begin
         state_n = IDLE;
         cnt_n   = '0;
         ctrl_n  = CTRL_W'(OP_ADD);
         md_n    = 1'b0;
         mdop_n  = 3'b000;
         ill_n   = 1'b0;
         vld_n   = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!stall_in) begin
                  if (!in_valid) begin
                     ctrl_n = CTRL_W'(OP_ADD);
                     md_n   = 1'b0;
                     mdop_n = 3'b000;
                     ill_n  = 1'b0;
                     vld_n  = 1'b0;
                  end else begin
                     ctrl_n = CTRL_W'(dec_op);
                     md_n   = dec_md;
                     mdop_n = dec_md ? funct3 : 3'b000;
                     ill_n  = dec_ill;
                     if (dec_md) begin
                        vld_n   = 1'b0;
                        state_n = MD_BUSY;
                        cnt_n   = funct3[2] ? DIV_CNT : MUL_CNT;
                     end else begin
                        vld_n = 1'b1;
                     end
                  end
               end
            end
            MD_BUSY: begin
               if (cnt == ONE) begin
                  state_n = IDLE;
                  cnt_n   = '0;
                  vld_n   = 1'b1;
               end else begin
                  cnt_n = cnt - ONE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         alu_control <= CTRL_W'(OP_ADD);
         is_md       <= 1'b0;
         md_op       <= 3'b000;
         illegal     <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         alu_control <= ctrl_n;
         is_md       <= md_n;
         md_op       <= mdop_n;
         illegal     <= ill_n;
         out_valid   <= vld_n;
      end
   end

   assign stall_req = (state == MD_BUSY);

endmodule
